alu_result_stage: RTL

//  Downstream stage of logic_unit: registers ALUOut/ZERO/Update_UC into the ALUOut register and branch flag.

---
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/alu_result_stage_if.sv
// Bus between logic_unit/control unit and alu_result_stage.
// EXC_COUNT_EN adds the ExcCount exception counter output.
interface alu_result_stage_if;
  logic [31:0] ALUOut_in;
  logic        OVERFLOW;
  logic        ZERO_in;
  logic        Update_UC;
  logic [31:0] PC;
  logic        ALUOutWrite;
  logic        OvfTrap;
  logic        OpcodeInvalid;
  logic        ExcAck;
  logic [31:0] ALUOutReg;
  logic        ZeroReg;
  logic        BranchTaken;
  logic [31:0] EPC;
  logic        ExcReq;
  logic [1:0]  ExcCause;
  logic [31:0] ExcVector;
`ifdef EXC_COUNT_EN
  logic [7:0]  ExcCount;
`endif

  modport master (
`ifdef EXC_COUNT_EN
    input  ExcCount,
`endif
    output ALUOut_in, OVERFLOW, ZERO_in, Update_UC, PC, ALUOutWrite,
    output OvfTrap, OpcodeInvalid, ExcAck,
    input  ALUOutReg, ZeroReg, BranchTaken, EPC, ExcReq, ExcCause, ExcVector
  );

  modport slave (
`ifdef EXC_COUNT_EN
    output ExcCount,
`endif
    input  ALUOut_in, OVERFLOW, ZERO_in, Update_UC, PC, ALUOutWrite,
    input  OvfTrap, OpcodeInvalid, ExcAck,
    output ALUOutReg, ZeroReg, BranchTaken, EPC, ExcReq, ExcCause, ExcVector
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result register stage with overflow / invalid-opcode trap FSM and req/ack handshake.
// EXC_COUNT_EN enables a saturating 8-bit count of exceptions entered.
module alu_result_stage #(
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] PC_ADJ     = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXC_REQ, EXC_DONE} state_t;

  state_t      state;
  logic [31:0] alu_q, epc_q, vec_q;
  logic        zero_q, br_q, req_q;
  logic [1:0]  cause_q;
  logic        ovf_trap, exc_enter;

  assign ovf_trap  = bus.ALUOutWrite & bus.OvfTrap & bus.OVERFLOW;
  assign exc_enter = (state == IDLE) & (bus.OpcodeInvalid | ovf_trap);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      br_q    <= 1'b0;
      epc_q   <= '0;
      req_q   <= 1'b0;
      cause_q <= 2'b00;
      vec_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // invalid opcode outranks overflow; a trapped result is never captured
          if (bus.OpcodeInvalid) begin
            epc_q   <= bus.PC - PC_ADJ;
            cause_q <= 2'b10;
            vec_q   <= VEC_OPCODE;
            req_q   <= 1'b1;
            state   <= EXC_REQ;
          end else if (ovf_trap) begin
            epc_q   <= bus.PC - PC_ADJ;
            cause_q <= 2'b01;
            vec_q   <= VEC_OVF;
            req_q   <= 1'b1;
            state   <= EXC_REQ;
          end else if (bus.ALUOutWrite) begin
            alu_q  <= bus.ALUOut_in;
            zero_q <= bus.ZERO_in;
            br_q   <= bus.Update_UC;
          end
        end
        EXC_REQ: begin
          if (bus.ExcAck) begin
            req_q <= 1'b0;
            state <= EXC_DONE;
          end
        end
        EXC_DONE: begin
          cause_q <= 2'b00;
          vec_q   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ALUOutReg   = alu_q;
  assign bus.ZeroReg     = zero_q;
  assign bus.BranchTaken = br_q;
  assign bus.EPC         = epc_q;
  assign bus.ExcReq      = req_q;
  assign bus.ExcCause    = cause_q;
  assign bus.ExcVector   = vec_q;

`ifdef EXC_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (exc_enter && cnt_q != 8'hFF)
      cnt_q <= cnt_q + 8'd1;
  end

  assign bus.ExcCount = cnt_q;
`endif

endmodule
